// File: rtl/mergesort_main_pkg.sv
// Shared constants, reset image, FSM encoding and address-window helpers for the merge-sort accelerator.
package mergesort_main_pkg;

  localparam int unsigned N  = 16;
  localparam int unsigned EW = 8;
  localparam int unsigned AW = 4;
  localparam int unsigned SAW = 7;

  localparam int unsigned DATA_BASE = 64;
  localparam int unsigned TEMP_BASE = 32;

  // Reset image of the data array, element 0 in the least significant byte.
  localparam logic [N*EW-1:0] INIT_VALS = {
    8'h01, 8'h12, 8'h40, 8'hFF, 8'h09, 8'h33, 8'hE0, 8'h05,
    8'h2A, 8'h00, 8'h80, 8'h7F, 8'h11, 8'hF3, 8'h05, 8'h1C
  };

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MERGE = 2'd1,
    ST_COPY  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  function automatic logic [EW-1:0] init_val(input logic [AW-1:0] idx);
    return INIT_VALS[int'(idx)*EW +: EW];
  endfunction

  function automatic logic in_window(input logic [SAW-1:0] addr, input int unsigned base);
    return (32'(addr) >= base) && (32'(addr) < base + N);
  endfunction

  function automatic logic [AW-1:0] window_idx(input logic [SAW-1:0] addr, input int unsigned base);
    return AW'(32'(addr) - base);
  endfunction

endpackage

// File: rtl/mergesort_main_mem.sv
// 16x8 register memory: engine side with NRD read lanes and one write, slave side with two channels.
module byte_mem2p
  import mergesort_main_pkg::*;
#(
  parameter bit          USE_INIT = 1'b0,
  parameter int unsigned NRD      = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NRD*AW-1:0] eng_raddr,
  output logic [NRD*EW-1:0] eng_rdata,
  input  logic              eng_we,
  input  logic [AW-1:0]     eng_waddr,
  input  logic [EW-1:0]     eng_wdata,
  input  logic [1:0]        slv_we,
  input  logic [2*AW-1:0]   slv_addr,
  input  logic [2*EW-1:0]   slv_wdata,
  output logic [2*EW-1:0]   slv_rdata
);

  logic [EW-1:0] mem [N];

  // Asynchronous read lanes for the sort engine and the slave decode.
  always_comb begin
    eng_rdata = '0;
    slv_rdata = '0;
    for (int r = 0; r < int'(NRD); r++) begin
      eng_rdata[r*EW +: EW] = mem[eng_raddr[r*AW +: AW]];
    end
    for (int c = 0; c < 2; c++) begin
      slv_rdata[c*EW +: EW] = mem[slv_addr[c*AW +: AW]];
    end
  end

  // Storage update; slave channel 1 is applied last so it wins a same-byte collision.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int idx = 0; idx < int'(N); idx++) begin
        mem[idx] <= USE_INIT ? init_val(AW'(idx)) : '0;
      end
    end else begin
      if (eng_we) mem[eng_waddr] <= eng_wdata;
      for (int c = 0; c < 2; c++) begin
        if (slv_we[c]) mem[slv_addr[c*AW +: AW]] <= slv_wdata[c*EW +: EW];
      end
    end
  end

endmodule

// File: rtl/mergesort_main.sv
// Bottom-up merge-sort accelerator over a 16-byte signed array with a two-channel byte slave port.
module mergesort_main
  import mergesort_main_pkg::*;
#(
  parameter int unsigned MEM_var_28859_28863 = DATA_BASE,
  parameter int unsigned MEM_var_28861_28867 = TEMP_BASE,
  parameter int unsigned MEM_var_28991_28863 = TEMP_BASE
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start_port,
  input  logic [1:0]  S_oe_ram,
  input  logic [1:0]  S_we_ram,
  input  logic [13:0] S_addr_ram,
  input  logic [15:0] S_Wdata_ram,
  input  logic [7:0]  S_data_ram_size,
  output logic        done_port,
  output logic [15:0] Sout_Rdata_ram,
  output logic [1:0]  Sout_DataRdy
);

  state_t        state;
  logic [4:0]    width, lo, i, j, k;
  logic [4:0]    mid, hi;
  logic [EW-1:0] left_val, right_val, merge_val, copy_val;
  logic          take_left;

  logic [1:0]    hit_data, hit_temp;
  logic [2*AW-1:0] data_slv_addr, temp_slv_addr;
  logic [1:0]    data_slv_we, temp_slv_we;
  logic [2*EW-1:0] data_slv_rd, temp_slv_rd;
  logic          unused_size;

  // Access size is always treated as one byte.
  assign unused_size = ^S_data_ram_size;

  byte_mem2p #(.USE_INIT(1'b1), .NRD(2)) u_data (
    .clock     (clock),
    .reset     (reset),
    .eng_raddr ({j[AW-1:0], i[AW-1:0]}),
    .eng_rdata ({right_val, left_val}),
    .eng_we    (state == ST_COPY),
    .eng_waddr (k[AW-1:0]),
    .eng_wdata (copy_val),
    .slv_we    (data_slv_we),
    .slv_addr  (data_slv_addr),
    .slv_wdata (S_Wdata_ram),
    .slv_rdata (data_slv_rd)
  );

  byte_mem2p #(.USE_INIT(1'b0), .NRD(1)) u_temp (
    .clock     (clock),
    .reset     (reset),
    .eng_raddr (k[AW-1:0]),
    .eng_rdata (copy_val),
    .eng_we    (state == ST_MERGE),
    .eng_waddr (k[AW-1:0]),
    .eng_wdata (merge_val),
    .slv_we    (temp_slv_we),
    .slv_addr  (temp_slv_addr),
    .slv_wdata (S_Wdata_ram),
    .slv_rdata (temp_slv_rd)
  );

  // Merge comparator: left run wins ties so equal keys keep their order.
  always_comb begin
    mid       = lo + width;
    hi        = lo + (width << 1);
    take_left = (i < mid) && ((j >= hi) || ($signed(left_val) <= $signed(right_val)));
    merge_val = take_left ? left_val : right_val;
  end

  // Slave address decode; writes reach memory only while idle.
  always_comb begin
    hit_data      = '0;
    hit_temp      = '0;
    data_slv_addr = '0;
    temp_slv_addr = '0;
    data_slv_we   = '0;
    temp_slv_we   = '0;
    for (int c = 0; c < 2; c++) begin
      hit_data[c] = in_window(S_addr_ram[c*SAW +: SAW], MEM_var_28859_28863);
      hit_temp[c] = in_window(S_addr_ram[c*SAW +: SAW], MEM_var_28861_28867) ||
                    in_window(S_addr_ram[c*SAW +: SAW], MEM_var_28991_28863);
      data_slv_addr[c*AW +: AW] = window_idx(S_addr_ram[c*SAW +: SAW], MEM_var_28859_28863);
      temp_slv_addr[c*AW +: AW] = window_idx(S_addr_ram[c*SAW +: SAW], MEM_var_28861_28867);
      data_slv_we[c] = S_we_ram[c] && hit_data[c] && (state == ST_IDLE);
      temp_slv_we[c] = S_we_ram[c] && hit_temp[c] && !hit_data[c] && (state == ST_IDLE);
    end
  end

  // Slave response: one-cycle acknowledge, read data captured before any same-edge write.
  always_ff @(posedge clock) begin
    if (reset) begin
      Sout_Rdata_ram <= '0;
      Sout_DataRdy   <= '0;
    end else begin
      Sout_DataRdy <= S_oe_ram | S_we_ram;
      for (int c = 0; c < 2; c++) begin
        if (S_oe_ram[c]) begin
          Sout_Rdata_ram[c*EW +: EW] <= hit_data[c] ? data_slv_rd[c*EW +: EW] :
                                        hit_temp[c] ? temp_slv_rd[c*EW +: EW] : '0;
        end
      end
    end
  end

  // Sort sequencer: merge pass into temp, copy back, double width until the array is one run.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= ST_IDLE;
      width     <= 5'd1;
      lo        <= '0;
      i         <= '0;
      j         <= '0;
      k         <= '0;
      done_port <= 1'b0;
    end else begin
      done_port <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start_port) begin
            state <= ST_MERGE;
            width <= 5'd1;
            lo    <= '0;
            i     <= '0;
            j     <= 5'd1;
            k     <= '0;
          end
        end
        ST_MERGE: begin
          if (take_left) i <= i + 5'd1;
          else           j <= j + 5'd1;
          if (k == hi - 5'd1) begin
            lo <= hi;
            i  <= hi;
            j  <= hi + width;
          end
          if (k == 5'd15) begin
            state <= ST_COPY;
            k     <= '0;
          end else begin
            k <= k + 5'd1;
          end
        end
        ST_COPY: begin
          if (k == 5'd15) begin
            k     <= '0;
            lo    <= '0;
            i     <= '0;
            j     <= width << 1;
            width <= width << 1;
            state <= (width == 5'd8) ? ST_DONE : ST_MERGE;
          end else begin
            k <= k + 5'd1;
          end
        end
        ST_DONE: begin
          done_port <= 1'b1;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mergesort_main.sv
// Scoreboard bench: stimulus pushes expected slave responses, a monitor pops and compares on each acknowledge.
module tb_mergesort_main;

  logic        clock = 1'b0;
  logic        reset, start_port;
  logic [1:0]  S_oe_ram, S_we_ram;
  logic [13:0] S_addr_ram;
  logic [15:0] S_Wdata_ram;
  logic [7:0]  S_data_ram_size;
  logic        done_port;
  logic [15:0] Sout_Rdata_ram;
  logic [1:0]  Sout_DataRdy;

  always #5 clock = ~clock;

  mergesort_main dut (
    .clock           (clock),
    .reset           (reset),
    .start_port      (start_port),
    .S_oe_ram        (S_oe_ram),
    .S_we_ram        (S_we_ram),
    .S_addr_ram      (S_addr_ram),
    .S_Wdata_ram     (S_Wdata_ram),
    .S_data_ram_size (S_data_ram_size),
    .done_port       (done_port),
    .Sout_Rdata_ram  (Sout_Rdata_ram),
    .Sout_DataRdy    (Sout_DataRdy)
  );

  typedef struct packed {
    logic       is_read;
    logic [7:0] data;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  logic [7:0] init_m [16] = '{8'h1C, 8'h05, 8'hF3, 8'h11, 8'h7F, 8'h80, 8'h00, 8'h2A,
                              8'h05, 8'hE0, 8'h33, 8'h09, 8'hFF, 8'h40, 8'h12, 8'h01};
  logic [7:0] data_m [16];
  logic [7:0] temp_m [16];
  bit         model_idle;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] model_rd(input logic [6:0] a);
    if (a >= 7'd64 && a < 7'd80) return data_m[int'(a) - 64];
    if (a >= 7'd32 && a < 7'd48) return temp_m[int'(a) - 32];
    return 8'h00;
  endfunction

  task automatic model_wr(input logic [6:0] a, input logic [7:0] d);
    if (a >= 7'd64 && a < 7'd80) data_m[int'(a) - 64] = d;
    else if (a >= 7'd32 && a < 7'd48) temp_m[int'(a) - 32] = d;
  endtask

  task automatic model_reset();
    for (int x = 0; x < 16; x++) begin
      data_m[x] = init_m[x];
      temp_m[x] = 8'h00;
    end
    model_idle = 1'b1;
  endtask

  // Stable ascending sort of the data array; the last merge pass leaves the same order in temp.
  task automatic model_sort();
    logic [7:0] key;
    int p;
    for (int x = 1; x < 16; x++) begin
      key = data_m[x];
      p = x - 1;
      while (p >= 0 && $signed(data_m[p]) > $signed(key)) begin
        data_m[p + 1] = data_m[p];
        p--;
      end
      data_m[p + 1] = key;
    end
    for (int x = 0; x < 16; x++) temp_m[x] = data_m[x];
  endtask

  // Expected responses for one bus cycle: all reads see pre-edge contents, then writes land (ch1 last).
  task automatic model_access(input logic [1:0] oe, input logic [1:0] we,
                              input logic [6:0] a0, input logic [6:0] a1,
                              input logic [7:0] d0, input logic [7:0] d1);
    exp_t e0, e1;
    e0.is_read = oe[0];
    e0.data    = model_rd(a0);
    e1.is_read = oe[1];
    e1.data    = model_rd(a1);
    if (oe[0] || we[0]) q0.push_back(e0);
    if (oe[1] || we[1]) q1.push_back(e1);
    if (model_idle) begin
      if (we[0]) model_wr(a0, d0);
      if (we[1]) model_wr(a1, d1);
    end
  endtask

  task automatic drive_bus(input logic [1:0] oe, input logic [1:0] we,
                           input logic [6:0] a0, input logic [6:0] a1,
                           input logic [7:0] d0, input logic [7:0] d1);
    S_oe_ram        = oe;
    S_we_ram        = we;
    S_addr_ram      = {a1, a0};
    S_Wdata_ram     = {d1, d0};
    S_data_ram_size = 8'($urandom);
    model_access(oe, we, a0, a1, d0, d1);
  endtask

  task automatic bus_cycle(input logic [1:0] oe, input logic [1:0] we,
                           input logic [6:0] a0, input logic [6:0] a1,
                           input logic [7:0] d0, input logic [7:0] d1);
    @(negedge clock);
    drive_bus(oe, we, a0, a1, d0, d1);
  endtask

  task automatic bus_idle();
    @(negedge clock);
    S_oe_ram    = '0;
    S_we_ram    = '0;
    S_addr_ram  = '0;
    S_Wdata_ram = '0;
  endtask

  task automatic read_all();
    for (int a = 0; a < 16; a++) begin
      bus_cycle(2'b11, 2'b00, 7'(64 + a), 7'(32 + a), 8'h00, 8'h00);
    end
    bus_idle();
  endtask

  // mode 0 plain, 1 extra starts while busy, 2 write while busy, 3 reset at cycle 60.
  task automatic run_sort(input int mode);
    int pulses;
    int first;
    bus_idle();
    @(negedge clock);
    start_port = 1'b1;
    @(posedge clock);
    #1;
    start_port = 1'b0;
    model_idle = 1'b0;
    pulses = 0;
    first  = -1;
    for (int n = 1; n <= 180; n++) begin
      @(posedge clock);
      #1;
      if (done_port) begin
        pulses++;
        if (first < 0) first = n;
      end
      if (mode == 1) start_port = (n == 10 || n == 50 || n == 128);
      if (mode == 2) begin
        if (n == 20) drive_bus(2'b00, 2'b11, 7'd64, 7'd40, 8'h77, 8'h66);
        if (n == 21) begin
          S_we_ram = '0;
          S_addr_ram = '0;
        end
      end
      if (mode == 3) begin
        if (n == 60) reset = 1'b1;
        if (n == 61) begin
          reset = 1'b0;
          check("rst_mid_done", 32'(done_port), 32'd0);
          check("rst_mid_rdy", 32'(Sout_DataRdy), 32'd0);
          check("rst_mid_rdata", 32'(Sout_Rdata_ram), 32'd0);
          model_reset();
        end
      end
    end
    start_port = 1'b0;
    model_idle = 1'b1;
    if (mode == 3) begin
      check("rst_mid_no_done", 32'(pulses), 32'd0);
    end else begin
      check("done_latency", 32'(first), 32'd129);
      check("done_pulses", 32'(pulses), 32'd1);
      model_sort();
    end
  endtask

  // Monitor: every acknowledge must match the oldest expectation on that channel.
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (Sout_DataRdy[0]) begin
        if (q0.size() == 0) check("ack0_unexpected", 32'(Sout_DataRdy[0]), 32'd0);
        else begin
          e = q0.pop_front();
          if (e.is_read) check("rd_ch0", 32'(Sout_Rdata_ram[7:0]), 32'(e.data));
        end
      end
      if (Sout_DataRdy[1]) begin
        if (q1.size() == 0) check("ack1_unexpected", 32'(Sout_DataRdy[1]), 32'd0);
        else begin
          e = q1.pop_front();
          if (e.is_read) check("rd_ch1", 32'(Sout_Rdata_ram[15:8]), 32'(e.data));
        end
      end
    end
  end

  initial begin
    logic [1:0] oe, we;
    logic [6:0] a0, a1;
    reset           = 1'b1;
    start_port      = 1'b0;
    S_oe_ram        = '0;
    S_we_ram        = '0;
    S_addr_ram      = '0;
    S_Wdata_ram     = '0;
    S_data_ram_size = 8'h88;
    model_reset();
    repeat (3) @(posedge clock);
    #1;
    check("rst_done", 32'(done_port), 32'd0);
    check("rst_rdy", 32'(Sout_DataRdy), 32'd0);
    check("rst_rdata", 32'(Sout_Rdata_ram), 32'd0);
    @(negedge clock);
    reset = 1'b0;

    // Reset image, then sort of the reset image.
    read_all();
    run_sort(0);
    read_all();

    // Descending load through alternating channels.
    for (int a = 0; a < 16; a++) begin
      bus_cycle(2'b00, (a % 2 == 1) ? 2'b10 : 2'b01, 7'(64 + a), 7'(64 + a),
                8'(15 - a), 8'(15 - a));
    end
    run_sort(0);
    read_all();

    // Ties: stability and unchanged latency.
    for (int a = 0; a < 16; a++) begin
      bus_cycle(2'b00, 2'b01, 7'(64 + a), 7'd0, (a == 0) ? 8'h80 : 8'h05, 8'h00);
    end
    run_sort(0);
    read_all();

    // Slave corner cases.
    bus_cycle(2'b01, 2'b00, 7'd0, 7'd0, 8'h00, 8'h00);
    bus_cycle(2'b00, 2'b11, 7'd70, 7'd70, 8'hAA, 8'h55);
    bus_cycle(2'b11, 2'b00, 7'd70, 7'd70, 8'h00, 8'h00);
    bus_cycle(2'b01, 2'b01, 7'd65, 7'd0, 8'h33, 8'h00);
    bus_cycle(2'b01, 2'b00, 7'd65, 7'd0, 8'h00, 8'h00);
    bus_cycle(2'b00, 2'b01, 7'd100, 7'd0, 8'hC3, 8'h00);
    bus_cycle(2'b11, 2'b00, 7'd100, 7'd127, 8'h00, 8'h00);
    bus_idle();

    // Randomised traffic followed by sorts.
    for (int it = 0; it < 3; it++) begin
      for (int t = 0; t < 40; t++) begin
        oe = 2'($urandom);
        we = 2'($urandom);
        case ($urandom_range(0, 3))
          0: a0 = 7'(32 + $urandom_range(0, 15));
          1: a0 = 7'($urandom_range(0, 127));
          default: a0 = 7'(64 + $urandom_range(0, 15));
        endcase
        a1 = ($urandom_range(0, 3) == 0) ? a0 : 7'(64 + $urandom_range(0, 15));
        bus_cycle(oe, we, a0, a1, 8'($urandom), 8'($urandom));
      end
      run_sort(0);
      read_all();
    end

    // Busy behaviour and reset mid-sort.
    run_sort(1);
    read_all();
    run_sort(2);
    read_all();
    run_sort(3);
    read_all();
    run_sort(0);
    read_all();

    repeat (3) @(posedge clock);
    #1;
    check("q0_drained", 32'(q0.size()), 32'd0);
    check("q1_drained", 32'(q1.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
